// File: rtl/coffee_machine.sv
// coffee_machine: coin-operated coffee vending controller that sums 1/2/3 rupee coins,
// serves a cup at PRICE with change, and refunds on timeout, power loss or missing milk.
module coffee_machine #(
    parameter int PRICE   = 7,
    parameter int TIMEOUT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] coin_in,
    input  logic       coin_inserted,
    input  logic       power_on,
    input  logic       milk_present,
    output logic       dispense,
    output logic [3:0] change
);
    typedef enum logic [1:0] {IDLE, COUNTING, DISPENSE, REFUND} state_t;

    localparam logic [3:0] PRICE_W   = 4'(PRICE);
    localparam logic [2:0] TIMEOUT_W = 3'(TIMEOUT);

    state_t     state_q, state_d;
    logic [3:0] total_q, total_d;
    logic [2:0] timeout_counter_q, timeout_counter_d;
    logic       accept;
    logic [3:0] sum;

    assign accept = coin_inserted && coin_in != 2'b00 && power_on &&
                    (state_q == IDLE || state_q == COUNTING);
    assign sum    = total_q + {2'b00, coin_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            total_q           <= '0;
            timeout_counter_q <= '0;
        end else begin
            state_q           <= state_d;
            total_q           <= total_d;
            timeout_counter_q <= timeout_counter_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        total_d           = total_q;
        timeout_counter_d = timeout_counter_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    total_d = sum;
                    state_d = sum >= PRICE_W ? DISPENSE : COUNTING;
                end
            end
            COUNTING: begin
                if (!power_on) begin
                    state_d = REFUND;
                end else if (accept) begin
                    total_d           = sum;
                    timeout_counter_d = '0;
                    state_d           = sum >= PRICE_W ? DISPENSE : COUNTING;
                end else begin
                    timeout_counter_d = timeout_counter_q == 3'h7 ? timeout_counter_q
                                                                   : timeout_counter_q + 3'd1;
                    if (timeout_counter_q >= TIMEOUT_W) state_d = REFUND;
                end
            end
            DISPENSE: begin
                // Without milk the money is kept one more cycle so REFUND can return it
                if (milk_present) begin
                    state_d           = IDLE;
                    total_d           = '0;
                    timeout_counter_d = '0;
                end else begin
                    state_d = REFUND;
                end
            end
            default: begin
                state_d           = IDLE;
                total_d           = '0;
                timeout_counter_d = '0;
            end
        endcase
    end

    always_comb begin
        dispense = state_q == DISPENSE && milk_present;
        change   = dispense          ? total_q - PRICE_W :
                   state_q == REFUND ? total_q : 4'd0;
    end
endmodule

// File: tb/tb_coffee_machine.sv
// tb_coffee_machine: directed scenarios plus randomized traffic checked against
// a transaction-level model of paid money, idle time and the owed outcome.
module tb_coffee_machine;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] coin_in = 2'b00;
    logic       coin_inserted = 1'b0;
    logic       power_on = 1'b0;
    logic       milk_present = 1'b0;
    logic       dispense;
    logic [3:0] change;

    int checks = 0;
    int failures = 0;

    int paid = 0;
    int idle_cnt = 0;
    int due = 0;
    int obs_d, obs_c;

    coffee_machine dut (
        .clk(clk), .reset(reset), .coin_in(coin_in), .coin_inserted(coin_inserted),
        .power_on(power_on), .milk_present(milk_present), .dispense(dispense), .change(change)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        paid = 0;
        idle_cnt = 0;
        due = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        coin_inserted = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_dispense", int'(dispense), 0);
        check("rst_change", int'(change), 0);
        clear_model();
        #2;
        reset = 1'b1;
    endtask

    // due: 0 = still collecting, 1 = cup owed this cycle, 2 = refund owed this cycle
    task automatic step(input bit strobe, input int coin, input bit pwr, input bit milk);
        int  exp_d, exp_c;
        bit  acc;
        @(negedge clk);
        coin_inserted = strobe;
        coin_in = coin[1:0];
        power_on = pwr;
        milk_present = milk;
        #1;
        exp_d = 0;
        exp_c = 0;
        if (due == 1 && milk) begin
            exp_d = 1;
            exp_c = paid - 7;
        end
        if (due == 2) exp_c = paid;
        obs_d = int'(dispense);
        obs_c = int'(change);
        check("dispense", obs_d, exp_d);
        check("change", obs_c, exp_c);
        acc = strobe && coin != 0 && pwr && due == 0;
        if (due == 1) begin
            if (milk) clear_model();
            else due = 2;
        end else if (due == 2) begin
            clear_model();
        end else if (paid == 0) begin
            if (acc) paid = coin;
        end else if (!pwr) begin
            due = 2;
        end else if (acc) begin
            paid += coin;
            idle_cnt = 0;
            if (paid >= 7) due = 1;
        end else if (idle_cnt >= 3) begin
            due = 2;
        end else begin
            idle_cnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 1);
    endtask

    initial begin
        #1;
        check("por_dispense", int'(dispense), 0);
        check("por_change", int'(change), 0);
        do_reset();
        step(1, 3, 0, 1);
        step(0, 0, 1, 1);
        check("pwr_off_change", obs_c, 0);
        idle(2);
        step(1, 3, 1, 1); idle(1); step(1, 2, 1, 1); idle(1); step(1, 2, 1, 1);
        step(0, 0, 1, 1);
        check("exact_cup", obs_d, 1);
        check("exact_change", obs_c, 0);
        step(1, 3, 1, 1); step(1, 3, 1, 1); step(1, 3, 1, 1);
        step(0, 0, 1, 1);
        check("over_cup", obs_d, 1);
        check("over_change", obs_c, 2);
        step(0, 0, 1, 1);
        check("over_after", obs_c, 0);
        step(1, 3, 1, 1); step(1, 3, 1, 1); step(1, 1, 1, 1);
        step(1, 3, 1, 1);
        check("b2b_cup1", obs_d, 1);
        step(1, 3, 1, 1); step(1, 2, 1, 1); step(1, 2, 1, 1);
        step(0, 0, 1, 1);
        check("b2b_cup2", obs_d, 1);
        check("b2b_change2", obs_c, 0);
        step(1, 3, 1, 0); step(1, 2, 1, 0); step(1, 2, 1, 0);
        step(0, 0, 1, 0);
        check("nomilk_cup", obs_d, 0);
        check("nomilk_change0", obs_c, 0);
        step(0, 0, 1, 0);
        check("nomilk_refund", obs_c, 7);
        step(1, 3, 1, 1); step(1, 2, 1, 1); step(1, 1, 1, 1);
        idle(4);
        check("timeout_early", obs_c, 0);
        idle(1);
        check("timeout_refund", obs_c, 6);
        step(1, 3, 1, 1); step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        check("pwr_loss_refund", obs_c, 3);
        step(1, 3, 1, 1); step(1, 3, 1, 1);
        do_reset();
        idle(6);
        check("rst_discard", obs_c, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                     $urandom_range(0, 19) != 0, $urandom_range(0, 4) != 0);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
